// File: rtl/wt_dcache_inval_ctrl_pkg.sv
// Cache geometry constants and the invalidation sequencer state type.
// ariane_pkg carries core-wide cache geometry; wt_cache_pkg the write-through dcache specifics.
package ariane_pkg;
  localparam int unsigned DCACHE_SET_ASSOC = 8;
endpackage

package wt_cache_pkg;
  localparam int unsigned DCACHE_NUM_WORDS    = 256;
  localparam int unsigned DCACHE_CL_IDX_WIDTH = $clog2(DCACHE_NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    INVAL,
    DONE
  } inval_state_e;
endpackage

// File: rtl/wt_dcache_inval_ctrl.sv
// Invalidation sequencer for the write-through dcache: clears valid bits either by
// walking every set (flush) or for selected ways of a single set.
module wt_dcache_inval_ctrl
  import wt_cache_pkg::*;
#(
  parameter int unsigned NumWays  = ariane_pkg::DCACHE_SET_ASSOC,
  parameter int unsigned NumSets  = DCACHE_NUM_WORDS,
  parameter int unsigned IdxWidth = $clog2(NumSets)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  output logic                flush_ack_o,
  input  logic                inval_vld_i,
  input  logic [IdxWidth-1:0] inval_idx_i,
  input  logic [NumWays-1:0]  inval_way_i,
  output logic                inval_ack_o,
  output logic                wr_cl_vld_o,
  input  logic                wr_cl_gnt_i,
  output logic [NumWays-1:0]  wr_cl_we_o,
  output logic [IdxWidth-1:0] wr_cl_idx_o,
  output logic [NumWays-1:0]  wr_vld_bits_o,
  output logic                busy_o
);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumSets - 1);

  inval_state_e        state;
  logic [IdxWidth-1:0] cnt;
  logic [IdxWidth-1:0] idx_q;
  logic [NumWays-1:0]  way_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      idx_q <= '0;
      way_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Flush wins over a concurrent single-set request; the latter waits in IDLE.
          if (flush_i) begin
            state <= FLUSH;
            cnt   <= '0;
          end else if (inval_vld_i && (|inval_way_i)) begin
            state <= INVAL;
            idx_q <= inval_idx_i;
            way_q <= inval_way_i;
          end
        end
        FLUSH: begin
          if (wr_cl_gnt_i) begin
            if (cnt == LastIdx) begin
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        INVAL: begin
          if (wr_cl_gnt_i) begin
            state <= IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write-port signals decode from registered state only, so they hold while ungranted.
  assign wr_cl_vld_o   = (state == FLUSH) || (state == INVAL);
  assign wr_cl_idx_o   = (state == FLUSH) ? cnt :
                         (state == INVAL) ? idx_q : '0;
  assign wr_cl_we_o    = (state == FLUSH) ? {NumWays{1'b1}} :
                         (state == INVAL) ? way_q : '0;
  assign wr_vld_bits_o = '0;

  assign flush_ack_o = (state == DONE);
  // An empty way mask needs no write and is acknowledged straight from IDLE.
  assign inval_ack_o = ((state == INVAL) && wr_cl_gnt_i) ||
                       ((state == IDLE) && !flush_i && inval_vld_i && !(|inval_way_i));
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_wt_dcache_inval_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-of-pending-writes reference model.
module tb_wt_dcache_inval_ctrl;
  localparam int NW = 8;
  localparam int NS = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          inval_vld_i = 1'b0;
  logic [IW-1:0] inval_idx_i = '0;
  logic [NW-1:0] inval_way_i = '0;
  logic          wr_cl_gnt_i = 1'b0;
  logic          flush_ack_o;
  logic          inval_ack_o;
  logic          wr_cl_vld_o;
  logic [NW-1:0] wr_cl_we_o;
  logic [IW-1:0] wr_cl_idx_o;
  logic [NW-1:0] wr_vld_bits_o;
  logic          busy_o;

  wt_dcache_inval_ctrl #(
    .NumWays (NW),
    .NumSets (NS),
    .IdxWidth(IW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .flush_ack_o  (flush_ack_o),
    .inval_vld_i  (inval_vld_i),
    .inval_idx_i  (inval_idx_i),
    .inval_way_i  (inval_way_i),
    .inval_ack_o  (inval_ack_o),
    .wr_cl_vld_o  (wr_cl_vld_o),
    .wr_cl_gnt_i  (wr_cl_gnt_i),
    .wr_cl_we_o   (wr_cl_we_o),
    .wr_cl_idx_o  (wr_cl_idx_o),
    .wr_vld_bits_o(wr_vld_bits_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the outstanding work is a queue of cacheline writes still to be
  // granted, plus a pending flush acknowledge once the last flush write has landed.
  typedef struct {
    logic [IW-1:0] idx;
    logic [NW-1:0] we;
    bit            is_flush;
    bit            last;
  } wr_t;

  wr_t pend[$];
  bit  ack_due = 0;
  bit  model_ready = 0;

  always @(posedge clk) begin : model
    wr_t w;
    if (!rst_ni) begin
      pend.delete();
      ack_due = 0;
      model_ready = 1;
    end else if (!model_ready) begin
      ack_due = 0;
    end else if (ack_due) begin
      ack_due = 0;
    end else if (pend.size() > 0) begin
      if (wr_cl_gnt_i) begin
        w = pend.pop_front();
        if (w.is_flush && w.last) ack_due = 1;
      end
    end else if (flush_i) begin
      for (int s = 0; s < NS; s++) begin
        w.idx = IW'(s);
        w.we = {NW{1'b1}};
        w.is_flush = 1;
        w.last = (s == NS - 1);
        pend.push_back(w);
      end
    end else if (inval_vld_i && inval_way_i != '0) begin
      w.idx = inval_idx_i;
      w.we = inval_way_i;
      w.is_flush = 0;
      w.last = 1;
      pend.push_back(w);
    end
  end

  // Per-cycle comparison, sampled 2 time units after the falling edge.
  always @(negedge clk) begin : compare
    logic e_vld;
    logic e_iack;
    #2;
    if (model_ready) begin
      e_vld = (pend.size() > 0);
      e_iack = 1'b0;
      if (e_vld) begin
        if (!pend[0].is_flush && wr_cl_gnt_i) e_iack = 1'b1;
      end else if (!ack_due && !flush_i && inval_vld_i && inval_way_i == '0) begin
        e_iack = 1'b1;
      end
      chk("m_wr_vld", 32'(wr_cl_vld_o), 32'(e_vld));
      if (e_vld) begin
        chk("m_wr_idx", 32'(wr_cl_idx_o), 32'(pend[0].idx));
        chk("m_wr_we", 32'(wr_cl_we_o), 32'(pend[0].we));
      end
      chk("m_vld_bits", 32'(wr_vld_bits_o), 32'(0));
      chk("m_flush_ack", 32'(flush_ack_o), 32'(ack_due));
      chk("m_inval_ack", 32'(inval_ack_o), 32'(e_iack));
      chk("m_busy", 32'(busy_o), 32'(e_vld || ack_due));
    end
  end

  initial begin : drive
    int  grants;
    int  inval_wr;
    bit  fack_seen;
    bit  iack_seen;
    bit  f_acked;
    bit  i_acked;
    bit  hit;

    // Reset state
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("rst_vld", 32'(wr_cl_vld_o), 0);
    chk("rst_idx", 32'(wr_cl_idx_o), 0);
    chk("rst_we", 32'(wr_cl_we_o), 0);
    chk("rst_fack", 32'(flush_ack_o), 0);
    chk("rst_busy", 32'(busy_o), 0);

    // Flush, grant tied high: indices 0..7, ack on cycle 9, idle on cycle 10
    @(negedge clk);
    flush_i = 1'b1;
    wr_cl_gnt_i = 1'b1;
    for (int k = 0; k < NS; k++) begin
      @(negedge clk);
      #1;
      chk("flush_idx", 32'(wr_cl_idx_o), k);
      chk("flush_we", 32'(wr_cl_we_o), 32'hFF);
      chk("flush_vld", 32'(wr_cl_vld_o), 1);
      chk("flush_ack_early", 32'(flush_ack_o), 0);
    end
    @(negedge clk);
    #1;
    chk("flush_ack", 32'(flush_ack_o), 1);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("flush_busy_after", 32'(busy_o), 0);
    chk("flush_ack_once", 32'(flush_ack_o), 0);

    // Flush with toggling grant: index held across ungranted cycles
    @(negedge clk);
    flush_i = 1'b1;
    wr_cl_gnt_i = 1'b0;
    grants = 0;
    fack_seen = 0;
    for (int c = 0; c < 40 && !fack_seen; c++) begin
      @(negedge clk);
      wr_cl_gnt_i = ~wr_cl_gnt_i;
      #1;
      if (wr_cl_vld_o) begin
        chk("toggle_idx", 32'(wr_cl_idx_o), grants);
        if (wr_cl_gnt_i) grants++;
      end
      if (flush_ack_o) fack_seen = 1;
    end
    chk("toggle_ack_seen", 32'(fack_seen), 1);
    chk("toggle_grants", grants, NS);
    @(negedge clk);
    flush_i = 1'b0;
    wr_cl_gnt_i = 1'b0;

    // Single-set invalidation with grant delayed 3 cycles
    @(negedge clk);
    inval_vld_i = 1'b1;
    inval_idx_i = 3'd5;
    inval_way_i = 8'b0000_0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("inval_vld", 32'(wr_cl_vld_o), 1);
      chk("inval_idx", 32'(wr_cl_idx_o), 5);
      chk("inval_we", 32'(wr_cl_we_o), 32'h04);
      chk("inval_ack_early", 32'(inval_ack_o), 0);
    end
    @(negedge clk);
    wr_cl_gnt_i = 1'b1;
    #1;
    chk("inval_ack_with_gnt", 32'(inval_ack_o), 1);
    @(negedge clk);
    inval_vld_i = 1'b0;
    wr_cl_gnt_i = 1'b0;
    #1;
    chk("inval_busy_after", 32'(busy_o), 0);

    // Flush and invalidation raised together: flush served first
    @(negedge clk);
    flush_i = 1'b1;
    inval_vld_i = 1'b1;
    inval_idx_i = 3'd2;
    inval_way_i = 8'h01;
    wr_cl_gnt_i = 1'b1;
    fack_seen = 0;
    iack_seen = 0;
    inval_wr = 0;
    for (int c = 0; c < 40 && !iack_seen; c++) begin
      @(negedge clk);
      if (fack_seen) flush_i = 1'b0;
      #1;
      if (wr_cl_vld_o && wr_cl_gnt_i && fack_seen && wr_cl_idx_o == 3'd2 && wr_cl_we_o == 8'h01)
        inval_wr++;
      if (inval_ack_o) begin
        chk("both_inval_after_flush", 32'(fack_seen), 1);
        iack_seen = 1;
      end
      if (flush_ack_o) fack_seen = 1;
    end
    chk("both_iack_seen", 32'(iack_seen), 1);
    chk("both_inval_writes", inval_wr, 1);
    @(negedge clk);
    inval_vld_i = 1'b0;
    flush_i = 1'b0;
    wr_cl_gnt_i = 1'b0;

    // Empty way mask: acknowledged in IDLE without a write
    @(negedge clk);
    inval_vld_i = 1'b1;
    inval_idx_i = 3'd3;
    inval_way_i = 8'h00;
    #1;
    chk("noway_ack", 32'(inval_ack_o), 1);
    chk("noway_vld", 32'(wr_cl_vld_o), 0);
    @(negedge clk);
    inval_vld_i = 1'b0;
    #1;
    chk("noway_vld_after", 32'(wr_cl_vld_o), 0);
    chk("noway_busy_after", 32'(busy_o), 0);

    // Reset mid-flush at cnt=3
    @(negedge clk);
    flush_i = 1'b1;
    wr_cl_gnt_i = 1'b1;
    hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      #1;
      if (wr_cl_vld_o && wr_cl_idx_o == 3'd3) begin
        hit = 1;
        rst_ni = 1'b0;
        flush_i = 1'b0;
      end
    end
    chk("rstmid_reached_cnt3", 32'(hit), 1);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    chk("rstmid_vld", 32'(wr_cl_vld_o), 0);
    chk("rstmid_idx", 32'(wr_cl_idx_o), 0);
    chk("rstmid_we", 32'(wr_cl_we_o), 0);
    chk("rstmid_busy", 32'(busy_o), 0);
    fack_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (flush_ack_o) fack_seen = 1;
    end
    chk("rstmid_no_ack", 32'(fack_seen), 0);
    wr_cl_gnt_i = 1'b0;

    // Randomized traffic against the reference model
    f_acked = 0;
    i_acked = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0) begin
        rst_ni = 1'b0;
        flush_i = 1'b0;
        inval_vld_i = 1'b0;
        f_acked = 0;
        i_acked = 0;
      end else begin
        rst_ni = 1'b1;
        if (f_acked) begin
          flush_i = 1'b0;
          f_acked = 0;
        end else if (!flush_i && $urandom_range(0, 39) == 0) begin
          flush_i = 1'b1;
        end
        if (i_acked) begin
          inval_vld_i = 1'b0;
          i_acked = 0;
        end else if (!inval_vld_i && $urandom_range(0, 5) == 0) begin
          inval_vld_i = 1'b1;
          inval_idx_i = IW'($urandom);
          inval_way_i = ($urandom_range(0, 4) == 0) ? '0 : NW'($urandom);
        end
      end
      wr_cl_gnt_i = ($urandom_range(0, 2) != 0);
      #1;
      if (rst_ni && flush_ack_o) f_acked = 1;
      if (rst_ni && inval_ack_o) i_acked = 1;
    end

    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
